// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for a small MIPS-style core.
//
// Sequences every instruction through FETCH / DECODE / EXEC / MEM / WB,
// parks in MD_WAIT while the multiply/divide unit works, and diverts to EXC
// for interrupts, syscall and reserved instructions.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   reset     : asynchronous, active-low reset
//   instr     : instruction register contents
//   zero      : ALU equality flag, sampled by beq in EXEC
//   irq       : interrupt request, already masked by CP0 IM/IE
//   exl       : CP0 EXL bit; blocks interrupts while set
//   pc_we, ir_we, reg_we, mem_we, hilo_we, cp0_we : write enables
//   regdst    : 0=rt, 1=rd, 2=$31
//   alusrc    : 0=register, 1=extended immediate
//   memtoreg  : 0=ALU, 1=memory/CP0, 2=PC+4, 3=HI/LO
//   pcsel     : 0=PC+4, 1=branch, 2=jal, 3=jr, 4=EPC, 5=exception vector
//   extop     : 0=zero, 1=sign, 2=lui shift, 3=branch offset, 4=jump index
//   aluop     : 0=add, 1=sub, 2=or, 3=equal
//   md_start  : one-cycle pulse launching the mult/div unit
//   exc_req, exc_code, exc_pc : exception request, cause code, handler address
//   busy      : high while waiting on the mult/div unit

module mc_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        irq,
  input  logic        exl,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        hilo_we,
  output logic        cp0_we,
  output logic [1:0]  regdst,
  output logic        alusrc,
  output logic [1:0]  memtoreg,
  output logic [2:0]  pcsel,
  output logic [2:0]  extop,
  output logic [3:0]  aluop,
  output logic        md_start,
  output logic        exc_req,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_MD_WAIT = 3'd5,
    S_EXC     = 3'd6
  } state_e;

  typedef enum logic [4:0] {
    I_NOP, I_ADD, I_SUB, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_JR,
    I_SYSCALL, I_MFC0, I_MTC0, I_ERET, I_MULT, I_MULTU, I_DIV, I_DIVU,
    I_MFHI, I_MFLO, I_MTHI, I_MTLO, I_RI
  } instr_e;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;

  // The EXEC cycle is the first of the N cycles, so MD_WAIT starts at N-1.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);
  localparam bit         MULT_ONE  = (MULT_CYCLES == 1);
  localparam bit         DIV_ONE   = (DIV_CYCLES == 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  excCode_q, excCode_d;
  instr_e      cls;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;

  logic        pcWeComb, irWeComb, regWeComb, memWeComb, hiloWeComb, cp0WeComb;
  logic        mdStartComb, excReqComb;
  logic [2:0]  pcselComb;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];

  // Instruction classification. Only the all-zero word is a nop; every other
  // unlisted encoding, including COP0 with an unexpected rs, is reserved.
  always_comb begin
    cls = I_RI;
    if (instr == 32'h0000_0000) begin
      cls = I_NOP;
    end else begin
      case (opcode)
        6'h00: begin
          case (funct)
            6'h20:   cls = I_ADD;
            6'h22:   cls = I_SUB;
            6'h08:   cls = I_JR;
            6'h0C:   cls = I_SYSCALL;
            6'h10:   cls = I_MFHI;
            6'h11:   cls = I_MTHI;
            6'h12:   cls = I_MFLO;
            6'h13:   cls = I_MTLO;
            6'h18:   cls = I_MULT;
            6'h19:   cls = I_MULTU;
            6'h1A:   cls = I_DIV;
            6'h1B:   cls = I_DIVU;
            default: cls = I_RI;
          endcase
        end
        6'h0D: cls = I_ORI;
        6'h0F: cls = I_LUI;
        6'h23: cls = I_LW;
        6'h2B: cls = I_SW;
        6'h04: cls = I_BEQ;
        6'h03: cls = I_JAL;
        6'h10: begin
          if (instr == 32'h4200_0018) begin
            cls = I_ERET;
          end else if (rs == 5'b00000) begin
            cls = I_MFC0;
          end else if (rs == 5'b00100) begin
            cls = I_MTC0;
          end else begin
            cls = I_RI;
          end
        end
        default: cls = I_RI;
      endcase
    end
  end

  // Datapath selects depend only on the held instruction, so they stay
  // steady for the whole life of an instruction after FETCH.
  always_comb begin
    regdst   = 2'd0;
    alusrc   = 1'b0;
    memtoreg = 2'd0;
    extop    = 3'd0;
    aluop    = 4'd0;
    case (cls)
      I_ADD:       regdst = 2'd1;
      I_SUB: begin
        regdst = 2'd1;
        aluop  = 4'd1;
      end
      I_ORI: begin
        alusrc = 1'b1;
        extop  = 3'd0;
        aluop  = 4'd2;
      end
      I_LUI: begin
        alusrc = 1'b1;
        extop  = 3'd2;
      end
      I_LW: begin
        alusrc   = 1'b1;
        extop    = 3'd1;
        memtoreg = 2'd1;
      end
      I_SW: begin
        alusrc = 1'b1;
        extop  = 3'd1;
      end
      I_BEQ: begin
        extop = 3'd3;
        aluop = 4'd3;
      end
      I_JAL: begin
        regdst   = 2'd2;
        memtoreg = 2'd2;
        extop    = 3'd4;
      end
      I_MFC0:      memtoreg = 2'd1;
      I_MFHI, I_MFLO: begin
        regdst   = 2'd1;
        memtoreg = 2'd3;
      end
      default: ;
    endcase
  end

  // Next-state and per-state control. Enables are Mealy where the state alone
  // is not enough (interrupt check in FETCH, beq outcome in EXEC).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    excCode_d   = excCode_q;
    pcWeComb    = 1'b0;
    irWeComb    = 1'b0;
    regWeComb   = 1'b0;
    memWeComb   = 1'b0;
    hiloWeComb  = 1'b0;
    cp0WeComb   = 1'b0;
    mdStartComb = 1'b0;
    excReqComb  = 1'b0;
    pcselComb   = 3'd0;
    case (state_q)
      S_FETCH: begin
        if (irq && !exl) begin
          state_d   = S_EXC;
          excCode_d = CODE_INT;
        end else begin
          irWeComb = 1'b1;
          pcWeComb = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          I_RI: begin
            state_d   = S_EXC;
            excCode_d = CODE_RI;
          end
          I_SYSCALL: begin
            state_d   = S_EXC;
            excCode_d = CODE_SYS;
          end
          I_NOP:   state_d = S_FETCH;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          I_BEQ: begin
            pcselComb = 3'd1;
            pcWeComb  = zero;
          end
          I_JAL: begin
            pcselComb = 3'd2;
            pcWeComb  = 1'b1;
            regWeComb = 1'b1;
          end
          I_JR: begin
            pcselComb = 3'd3;
            pcWeComb  = 1'b1;
          end
          I_ERET: begin
            pcselComb = 3'd4;
            pcWeComb  = 1'b1;
          end
          I_MTC0:         cp0WeComb  = 1'b1;
          I_MTHI, I_MTLO: hiloWeComb = 1'b1;
          I_MULT, I_MULTU: begin
            mdStartComb = 1'b1;
            if (MULT_ONE) begin
              hiloWeComb = 1'b1;
            end else begin
              cnt_d   = MULT_LOAD;
              state_d = S_MD_WAIT;
            end
          end
          I_DIV, I_DIVU: begin
            mdStartComb = 1'b1;
            if (DIV_ONE) begin
              hiloWeComb = 1'b1;
            end else begin
              cnt_d   = DIV_LOAD;
              state_d = S_MD_WAIT;
            end
          end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == I_SW) begin
          memWeComb = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        regWeComb = 1'b1;
        state_d   = S_FETCH;
      end
      // Interrupts are deliberately ignored here; they are taken at the
      // FETCH that follows the HI/LO write.
      S_MD_WAIT: begin
        cnt_d = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : 5'd0;
        if (cnt_q <= 5'd1) begin
          hiloWeComb = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXC: begin
        excReqComb = 1'b1;
        pcWeComb   = 1'b1;
        pcselComb  = 3'd5;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 5'd0;
      excCode_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      excCode_q <= excCode_d;
    end
  end

  // The state register already reads FETCH while reset is low, so the
  // strobes are gated with reset to keep FETCH's enables quiet during reset.
  assign pc_we    = pcWeComb    & reset;
  assign ir_we    = irWeComb    & reset;
  assign reg_we   = regWeComb   & reset;
  assign mem_we   = memWeComb   & reset;
  assign hilo_we  = hiloWeComb  & reset;
  assign cp0_we   = cp0WeComb   & reset;
  assign md_start = mdStartComb & reset;
  assign exc_req  = excReqComb  & reset;
  assign pcsel    = pcselComb;
  assign exc_code = excCode_q;
  assign exc_pc   = EXC_VECTOR;
  assign busy     = (state_q == S_MD_WAIT);

endmodule
